// File: rtl/conf_pkg.sv
// rtl/conf_pkg.sv - shared state encoding and frame defaults for the configuration frame sequencer
package conf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_COMMIT,
        S_TX_LOAD,
        S_TX_SHIFT,
        S_TX_START,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO
    } conf_state_e;

    localparam int          N_BYTES_DEF     = 11;
    localparam logic [7:0]  HDR_BYTE_DEF    = 8'h55;
    localparam int          TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/conf_tmo_cnt.sv
// rtl/conf_tmo_cnt.sv - saturating counter with clear/enable; tc flags the edge on which MAX_CNT is reached
module conf_tmo_cnt #(
    parameter int W       = 16,
    parameter int MAX_CNT = 49999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] MAX_V  = W'(MAX_CNT);
    localparam logic [W-1:0] LAST_V = W'(MAX_CNT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted in the cycle whose increment lands on MAX_CNT, so a clear in that cycle cancels it.
    assign tc = en && !clr && (cnt_q == LAST_V);

endmodule

// File: rtl/conf_frame_ctrl.sv
// rtl/conf_frame_ctrl.sv - receives header+payload, commits it to the config bank, then echoes it over UART TX
module conf_frame_ctrl
    import conf_pkg::*;
#(
    parameter int         N_BYTES     = N_BYTES_DEF,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_dw,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic       shift_rxregs,
    output logic       load_confregs,
    output logic       load_txregs,
    output logic       shift_txregs,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int              CW        = $clog2(N_BYTES + 1);
    localparam int              TW        = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]   LAST_BYTE = CW'(N_BYTES - 1);

    conf_state_e   state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic tx_start_q, tx_start_d;
    logic shift_rx_q, shift_rx_d;
    logic load_conf_q, load_conf_d;
    logic load_tx_q, load_tx_d;
    logic shift_tx_q, shift_tx_d;
    logic frame_ok_q, frame_ok_d;
    logic frame_err_q, frame_err_d;
    logic busy_q, busy_d;
    logic tmo_hit;

    conf_tmo_cnt #(
        .W       (TW),
        .MAX_CNT (TIMEOUT_CYC - 1)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != S_RX_PAYLOAD) || rx_valid),
        .en    ((state_q == S_RX_PAYLOAD) && !rx_valid),
        .tc    (tmo_hit)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        tx_start_d  = 1'b0;
        shift_rx_d  = 1'b0;
        load_conf_d = 1'b0;
        load_tx_d   = 1'b0;
        shift_tx_d  = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_dw == HDR_BYTE)) begin
                    state_d    = S_RX_PAYLOAD;
                    byte_cnt_d = '0;
                end
            end
            S_RX_PAYLOAD: begin
                if (rx_valid) begin
                    shift_rx_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_COMMIT;
                    end
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_COMMIT: begin
                load_conf_d = 1'b1;
                frame_ok_d  = 1'b1;
                state_d     = S_TX_LOAD;
            end
            S_TX_LOAD: begin
                load_tx_d = 1'b1;
                tx_cnt_d  = '0;
                state_d   = S_TX_SHIFT;
            end
            S_TX_SHIFT: begin
                shift_tx_d = 1'b1;
                state_d    = S_TX_START;
            end
            S_TX_START: begin
                tx_start_d = 1'b1;
                state_d    = S_TX_WAIT_HI;
            end
            S_TX_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_TX_WAIT_LO;
                end
            end
            S_TX_WAIT_LO: begin
                if (!tx_busy) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    state_d  = (tx_cnt_q == LAST_BYTE) ? S_IDLE : S_TX_SHIFT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            tx_cnt_q    <= '0;
            tx_start_q  <= 1'b0;
            shift_rx_q  <= 1'b0;
            load_conf_q <= 1'b0;
            load_tx_q   <= 1'b0;
            shift_tx_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_start_q  <= tx_start_d;
            shift_rx_q  <= shift_rx_d;
            load_conf_q <= load_conf_d;
            load_tx_q   <= load_tx_d;
            shift_tx_q  <= shift_tx_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_start      = tx_start_q;
    assign shift_rxregs  = shift_rx_q;
    assign load_confregs = load_conf_q;
    assign load_txregs   = load_tx_q;
    assign shift_txregs  = shift_tx_q;
    assign frame_ok      = frame_ok_q;
    assign frame_err     = frame_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_conf_frame_ctrl.sv
// tb/tb_conf_frame_ctrl.sv - scoreboard bench for conf_frame_ctrl with a 10-cycle UART TX busy model
module tb_conf_frame_ctrl;

    localparam logic [6:0] V_SHRX   = 7'b0100000;
    localparam logic [6:0] V_COMMIT = 7'b0010010;
    localparam logic [6:0] V_LDTX   = 7'b0001000;
    localparam logic [6:0] V_SHTX   = 7'b0000100;
    localparam logic [6:0] V_TXS    = 7'b1000000;
    localparam logic [6:0] V_ERR    = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_dw = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start, shift_rxregs, load_confregs, load_txregs, shift_txregs;
    logic       frame_ok, frame_err, busy;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt = 0;
    bit   mon_en = 1'b0;
    int   p;

    conf_frame_ctrl #(
        .N_BYTES     (11),
        .HDR_BYTE    (8'h55),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_dw         (rx_dw),
        .rx_valid      (rx_valid),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .shift_rxregs  (shift_rxregs),
        .load_confregs (load_confregs),
        .load_txregs   (load_txregs),
        .shift_txregs  (shift_txregs),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] out_vec();
        return {tx_start, shift_rxregs, load_confregs, load_txregs, shift_txregs, frame_ok, frame_err};
    endfunction

    // UART TX stand-in: busy for 10 cycles after each tx_start
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) begin
            tx_busy  = 1'b1;
            busy_cnt = 10;
        end
    end

    always @(negedge clk) begin
        logic [6:0] v;
        exp_t e;
        v = out_vec();
        if (mon_en && v != 7'd0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe cyc=%0d got=%b required=none", cyc, v);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec != v) begin
                    n_bad++;
                    $display("FAIL strobe got cyc=%0d vec=%b required cyc=%0d vec=%b", cyc, v, e.cyc, e.vec);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_dw    = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [7:0] b);
        push(cyc + 1, V_SHRX);
        rx_pulse(b);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Schedule after the last payload byte sampled at edge lp
    task automatic push_tx(input int lp, input int n);
        push(lp + 1, V_COMMIT);
        push(lp + 2, V_LDTX);
        for (int k = 0; k < n; k++) begin
            push(lp + 3 + 13 * k, V_SHTX);
            push(lp + 4 + 13 * k, V_TXS);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_strobes", int'(out_vec()), 0);
        check("reset_busy", int'(busy), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        rx_pulse(8'h00);
        @(negedge clk);
        rx_pulse(8'hAA);
        rx_pulse(8'h13);
        @(negedge clk);
        check("filter_busy", int'(busy), 0);
        rx_pulse(8'h55);
        check("header_busy", int'(busy), 1);

        for (int i = 1; i <= 11; i++) begin
            send_pay(8'(i));
            if (i < 11) @(negedge clk);
        end
        p = cyc;
        push_tx(p, 11);
        wait_to(p + 144);
        check("nominal_busy_hold", int'(busy), 1);
        @(negedge clk);
        check("nominal_busy_fall", int'(busy), 0);

        @(negedge clk);
        rx_pulse(8'h55);
        for (int i = 0; i < 5; i++) begin
            send_pay(8'h30 + 8'(i));
            if (i < 4) @(negedge clk);
        end
        p = cyc;
        push(p + 19, V_ERR);
        wait_to(p + 18);
        check("tmo_busy_hold", int'(busy), 1);
        @(negedge clk);
        check("tmo_busy_fall", int'(busy), 0);
        wait_to(p + 25);

        rx_pulse(8'h55);
        send_pay(8'h21);
        @(negedge clk);
        send_pay(8'h22);
        @(negedge clk);
        send_pay(8'h55);
        p = cyc;
        wait_to(p + 18);
        send_pay(8'h23);
        check("boundary_busy", int'(busy), 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            send_pay(8'h24 + 8'(i));
        end
        p = cyc;
        push_tx(p, 11);
        wait_to(p + 145);
        check("boundary_busy_fall", int'(busy), 0);

        @(negedge clk);
        rx_pulse(8'h55);
        for (int i = 0; i < 11; i++) begin
            send_pay(8'hA0 + 8'(i));
            if (i < 10) @(negedge clk);
        end
        p = cyc;
        push_tx(p, 4);
        rx_pulse(8'h55);
        wait_to(p + 19);
        rx_pulse(8'h55);
        wait_to(p + 29);
        rx_pulse(8'h07);
        wait_to(p + 43);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midtx_rst_strobes", int'(out_vec()), 0);
        check("midtx_rst_busy", int'(busy), 0);
        wait_to(p + 120);
        check("midtx_idle_busy", int'(busy), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
